// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies LENGTH bytes from page {src_page,00} into OAM after an
// FF46 write, owning the shared bus and fencing off non-HRAM CPU accesses meanwhile.
module oam_dma_controller #(
  parameter int LENGTH      = 160,
  parameter int START_DELAY = 1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  input  logic [15:0] i_CPU_Address,
  input  logic        i_CPU_Read,
  input  logic        i_CPU_Write,
  input  logic [7:0]  i_CPU_Data,
  output logic [7:0]  o_CPU_Data,
  output logic        o_CPU_Blocked,
  output logic [15:0] o_Bus_Address,
  output logic        o_Bus_Read,
  output logic        o_Bus_Write,
  output logic [7:0]  o_Bus_Data,
  input  logic [7:0]  i_Bus_Data,
  output logic [7:0]  o_OAM_Address,
  output logic [7:0]  o_OAM_Data,
  output logic        o_OAM_Write,
  output logic        o_DMA_Active
);

  typedef enum logic [1:0] {IDLE, START, TRANSFER} state_t;

  state_t     state, next_state;
  logic [7:0] reg_page;
  logic [7:0] src_page;
  logic [7:0] idx;
  logic [7:0] delay;
  logic       is_page_reg;
  logic       is_hram;
  logic       page_write;
  logic       last_byte;

  assign is_page_reg = (i_CPU_Address == 16'hFF46);
  assign is_hram     = (i_CPU_Address >= 16'hFF80) && (i_CPU_Address != 16'hFFFF);
  assign page_write  = i_Enable && i_CPU_Write && is_page_reg;
  assign last_byte   = (idx == 8'(LENGTH - 1));

  // A page write restarts the sequence from any state, overriding the final-byte exit.
  always_comb begin
    next_state = state;
    if (i_Enable) begin
      case (state)
        START:    if (delay == 8'd1) next_state = TRANSFER;
        TRANSFER: if (last_byte) next_state = IDLE;
        default:  next_state = state;
      endcase
    end
    if (page_write) next_state = START;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= IDLE;
      o_DMA_Active <= 1'b0;
    end else begin
      state        <= next_state;
      o_DMA_Active <= (next_state != IDLE);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      reg_page      <= 8'h00;
      src_page      <= 8'h00;
      idx           <= 8'h00;
      delay         <= 8'h00;
      o_OAM_Address <= 8'h00;
      o_OAM_Data    <= 8'h00;
      o_OAM_Write   <= 1'b0;
    end else begin
      o_OAM_Write <= i_Enable && (state == TRANSFER);
      if (i_Enable) begin
        if (state == START) delay <= delay - 8'd1;
        if (state == TRANSFER) begin
          o_OAM_Data    <= i_Bus_Data;
          o_OAM_Address <= idx;
          idx           <= idx + 8'd1;
        end
        // E0-FF source pages alias onto the C0-DF WRAM echo.
        if (page_write) begin
          reg_page <= i_CPU_Data;
          src_page <= (i_CPU_Data >= 8'hE0) ? (i_CPU_Data & 8'hDF) : i_CPU_Data;
          idx      <= 8'h00;
          delay    <= 8'(START_DELAY);
        end
      end
    end
  end

  always_comb begin
    o_Bus_Address = i_CPU_Address;
    o_Bus_Read    = i_CPU_Read;
    o_Bus_Write   = i_CPU_Write;
    o_Bus_Data    = i_CPU_Data;
    o_CPU_Data    = i_Bus_Data;
    o_CPU_Blocked = 1'b0;
    if (state == TRANSFER) begin
      o_Bus_Address = {src_page, idx};
      o_Bus_Read    = 1'b1;
      o_Bus_Write   = 1'b0;
      if (!is_page_reg && !is_hram) begin
        o_CPU_Blocked = i_CPU_Read || i_CPU_Write;
        o_CPU_Data    = 8'hFF;
      end
    end
    if (is_page_reg) begin
      o_CPU_Data    = reg_page;
      o_CPU_Blocked = 1'b0;
      if (state != TRANSFER) begin
        o_Bus_Read  = 1'b0;
        o_Bus_Write = 1'b0;
      end
    end
  end

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sequences OAM DMA transfers and arbitrates the shared memory bus between the CPU and the DMA engine. A CPU write to register FF46 starts a 160-byte copy from page XX00 to OAM. The block sits between the CPU bus and the memory map decoder. While a transfer runs, the DMA engine owns the bus and CPU accesses outside HRAM are blocked.

## Interface
- LENGTH, 160: bytes per transfer (OAM index 0..LENGTH-1)
- START_DELAY, 1: M-cycle strobes between the FF46 write and the first transfer cycle (≥1)

- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous, active-high reset
- i_Enable  in  1  M-cycle strobe; all state advances only on clocks with i_Enable=1
- i_CPU_Address  in  16  CPU address
- i_CPU_Read  in  1  CPU read request
- i_CPU_Write  in  1  CPU write request
- i_CPU_Data  in  8  CPU write data
- o_CPU_Data  out  8  CPU read data
- o_CPU_Blocked  out  1  current CPU access is suppressed by DMA
- o_Bus_Address  out  16  address to the memory map
- o_Bus_Read  out  1  bus read
- o_Bus_Write  out  1  bus write (CPU only; DMA never writes the bus)
- o_Bus_Data  out  8  bus write data
- i_Bus_Data  in  8  bus read data
- o_OAM_Address  out  8  OAM write index (registered)
- o_OAM_Data  out  8  OAM write data (registered)
- o_OAM_Write  out  1  one-clock OAM write pulse (registered)
- o_DMA_Active  out  1  state ≠ IDLE (registered)

## Operation
- States:
  - IDLE: no transfer in progress.
  - START: counts START_DELAY strobes.
  - TRANSFER: copies one byte per strobe.
- Register FF46 (8-bit reg_page, reset 00):
  - A CPU write with i_Enable=1 loads reg_page and the source page.
  - Source page = i_CPU_Data & 8'hDF when i_CPU_Data ≥ E0; otherwise i_CPU_Data. This maps E0–FF into the C0–DF WRAM echo.
  - The write then sets idx=0 and delay=START_DELAY, and enters START.
  - This applies in any state: a write during START or TRANSFER restarts the transfer.
  - FF46 reads return reg_page.
  - FF46 accesses are never forwarded to the bus.
- START:
  - Each strobe decrements delay.
  - The strobe on which delay reaches 0 enters TRANSFER.
  - CPU is not blocked in START.
- TRANSFER bus ownership:
  - o_Bus_Address = {src_page, idx}, o_Bus_Read=1, o_Bus_Write=0.
- TRANSFER, on each strobe:
  - o_OAM_Data ← i_Bus_Data, o_OAM_Address ← idx, o_OAM_Write ← 1 for exactly one clock.
  - idx ← idx+1.
  - The strobe that copies idx = LENGTH-1 returns to IDLE.
- CPU blocking, TRANSFER only:
  - Applies to CPU accesses to addresses < FF80 or = FFFF, excluding FF46.
  - o_CPU_Blocked=1; reads return FF; writes are dropped.
  - HRAM (FF80–FFFE) accesses are not serviced by the bus during TRANSFER. o_CPU_Blocked=0 and o_CPU_Data=i_Bus_Data; the HRAM port is external to this block.
- Pass-through, when not in TRANSFER and not FF46:
  - o_Bus_Address=i_CPU_Address, o_Bus_Read=i_CPU_Read, o_Bus_Write=i_CPU_Write, o_Bus_Data=i_CPU_Data, o_CPU_Data=i_Bus_Data, o_CPU_Blocked=0.
- idx is 8 bits. LENGTH ≤ 256, so there is no wrap within a transfer.

## Timing
- Reset (asynchronous assert): state=IDLE, reg_page=00, src_page=00, idx=0, delay=0, o_OAM_Write=0, o_OAM_Address=00, o_OAM_Data=00, o_DMA_Active=0.
- Combinational outputs follow pass-through rules immediately after reset.
- FF46 write on strobe k:
  - o_DMA_Active=1 from the next clock.
  - TRANSFER entered at strobe k+START_DELAY.
  - Byte i is captured on strobe k+START_DELAY+1+i; its o_OAM_Write pulse appears on the following clock.
  - Last byte on strobe k+START_DELAY+LENGTH. o_DMA_Active falls on the next clock.
- Clocks with i_Enable=0 hold all state. o_OAM_Write is 0 on those clocks, except the pulse clock following a capture strobe.
- Reset asserted mid-transfer: immediate IDLE. No further OAM writes; any pulse in flight is cleared.
- FF46 write on the same strobe as the final byte: the final byte is still written, and the restart takes priority (next state START, not IDLE).

## Test plan
- Reset mid-TRANSFER at byte 50 → o_DMA_Active=0 and o_OAM_Write=0 immediately. CPU read of 0x0000 returns i_Bus_Data; FF46 reads 00.
- Write FF46=C1 with memory C100+i = i^5A, START_DELAY=1 → 160 OAM pulses at idx 0..159 with data i^5A. First pulse follows strobe k+2. o_DMA_Active deasserts one clock after strobe k+161.
- During TRANSFER, CPU read 0xC000 → o_CPU_Blocked=1, o_CPU_Data=FF, bus address unaffected. CPU read FF85 → o_CPU_Blocked=0. After IDLE, read C000 → pass-through.
- Write FF46=F2 → bus addresses D200..D29F; FF46 read returns F2.
- Write FF46=80 at byte 100, then FF46=81 → transfer restarts. Bus address 8100 appears after START_DELAY strobes, and idx restarts at 0.
- i_Enable held low for 10 clocks mid-transfer → idx, bus address and o_DMA_Active frozen; no OAM pulses.
